data_memory: RTL and testbench

- Byte-addressable, little-endian data memory for the MIPS CPU memory stage.
- Supports word, halfword and byte stores, plus signed/unsigned loads.
- Writes are synchronous; reads are combinational.
- Flags misaligned, invalid-size and out-of-range accesses on a combinational `exception` output, which feeds the CPU exception logic.

---
 rtl/data_memory.sv | 101 ++++++++++
 tb/tb_data_memory.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable little-endian data memory for the MIPS memory stage
// Synchronous byte/halfword/word stores, combinational sign/zero-extended loads, access-fault flag.
module data_memory #(
  parameter int ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  output logic [31:0] dout,
  output logic        exception
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic [8*DEPTH-1:0]   mem_flat;
  logic [7:0]           b0, b1, b2, b3;
  logic                 misaligned, bad_size, out_of_range, fault;
  logic                 store_ok;
  logic [1:0]           lane_sel;

  assign a0 = addr[ADDR_BITS-1:0];
  assign a1 = a0 + ADDR_BITS'(1);
  assign a2 = a0 + ADDR_BITS'(2);
  assign a3 = a0 + ADDR_BITS'(3);

  assign misaligned   = ((memSize == 2'b10) && (addr[1:0] != 2'b00)) ||
                        ((memSize == 2'b01) && addr[0]);
  assign bad_size     = (memSize == 2'b11);
  assign out_of_range = ((addr >> ADDR_BITS) != 32'd0);
  assign fault        = misaligned || bad_size || out_of_range;

  assign exception = (memRead || memWrite) && fault;
  assign store_ok  = memWrite && !fault;

  // Aligned stores never wrap, so the byte's lane inside din follows its own low index bits.
  assign lane_sel = 2'b00;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_byte
      localparam logic [ADDR_BITS-1:0] IDX = ADDR_BITS'(i);
      logic       wen;
      logic [1:0] lane;
      logic [7:0] wdata;
      logic [7:0] q;

      always_comb begin
        wen  = 1'b0;
        lane = lane_sel;
        case (memSize)
          2'b00: wen = (a0 == IDX);
          2'b01: begin
            wen  = (a0[ADDR_BITS-1:1] == IDX[ADDR_BITS-1:1]);
            lane = {1'b0, IDX[0]};
          end
          2'b10: begin
            wen  = (a0[ADDR_BITS-1:2] == IDX[ADDR_BITS-1:2]);
            lane = IDX[1:0];
          end
          default: wen = 1'b0;
        endcase
      end

      assign wdata = din[{lane, 3'b000} +: 8];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= 8'h00;
        end else if (store_ok && wen) begin
          q <= wdata;
        end
      end

      assign mem_flat[8*i +: 8] = q;
    end
  endgenerate

  assign b0 = mem_flat[{a0, 3'b000} +: 8];
  assign b1 = mem_flat[{a1, 3'b000} +: 8];
  assign b2 = mem_flat[{a2, 3'b000} +: 8];
  assign b3 = mem_flat[{a3, 3'b000} +: 8];

  always_comb begin
    dout = 32'h0;
    if (memRead && !fault && !reset) begin
      case (memSize)
        2'b10:   dout = {b3, b2, b1, b0};
        2'b01:   dout = {{16{memSign & b1[7]}}, b1, b0};
        2'b00:   dout = {{24{memSign & b0[7]}}, b0};
        default: dout = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
// Linear sequence of stores/loads with hand-computed expectations.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] din;
  logic        memWrite;
  logic        memRead;
  logic [1:0]  memSize;
  logic        memSign;
  logic [31:0] dout;
  logic        exception;

  int passed = 0;
  int total  = 0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  data_memory #(.ADDR_BITS(12)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .din(din),
    .memWrite(memWrite),
    .memRead(memRead),
    .memSize(memSize),
    .memSign(memSign),
    .dout(dout),
    .exception(exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle();
    memWrite = 1'b0;
    memRead  = 1'b0;
    memSize  = SZ_W;
    memSign  = 1'b0;
    addr     = 32'h0;
    din      = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    addr = a; din = d; memSize = sz; memWrite = 1'b1; memRead = 1'b0;
    @(posedge clk);
    #1;
    memWrite = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
    addr = a; memSize = sz; memSign = sgn; memRead = 1'b1; memWrite = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    @(negedge clk);

    load(32'd0, SZ_W, 1'b0);
    chk("reset_lw0", dout, 32'h0);
    chk("reset_exc", {31'd0, exception}, 32'd0);

    store(32'd0, 32'h12345678, SZ_W);
    store(32'd4, 32'h12345678, SZ_H);
    store(32'd6, 32'hFFFFFFFF, SZ_B);
    store(32'd7, 32'hEEEEEEEE, SZ_B);
    @(negedge clk);

    load(32'd0, SZ_W, 1'b0);
    chk("lw0", dout, 32'h12345678);
    chk("lw0_exc", {31'd0, exception}, 32'd0);
    load(32'd4, SZ_W, 1'b0);
    chk("lw4_lanes", dout, 32'hEEFF5678);

    load(32'd6, SZ_H, 1'b1);
    chk("lh6", dout, 32'hFFFFEEFF);
    load(32'd6, SZ_H, 1'b0);
    chk("lhu6", dout, 32'h0000EEFF);
    load(32'd4, SZ_H, 1'b1);
    chk("lh4", dout, 32'h00005678);

    load(32'd0, SZ_B, 1'b1);
    chk("lb0", dout, 32'h00000078);
    load(32'd0, SZ_B, 1'b0);
    chk("lbu0", dout, 32'h00000078);
    load(32'd6, SZ_B, 1'b1);
    chk("lb6", dout, 32'hFFFFFFFF);
    load(32'd7, SZ_B, 1'b0);
    chk("lbu7", dout, 32'h000000EE);

    load(32'd3, SZ_W, 1'b0);
    chk("lw3_exc", {31'd0, exception}, 32'd1);
    chk("lw3_dout", dout, 32'h0);
    load(32'd5, SZ_H, 1'b1);
    chk("lh5_exc", {31'd0, exception}, 32'd1);
    memRead = 1'b0;

    @(negedge clk);
    addr = 32'd2; din = 32'hDEADBEEF; memSize = SZ_W; memWrite = 1'b1;
    #1;
    chk("sw2_exc", {31'd0, exception}, 32'd1);
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    load(32'd0, SZ_W, 1'b0);
    chk("sw2_nocommit", dout, 32'h12345678);
    load(32'd4, SZ_W, 1'b0);
    chk("sw2_nocommit4", dout, 32'hEEFF5678);

    load(32'd3, SZ_B, 1'b0);
    chk("lb3_exc", {31'd0, exception}, 32'd0);
    chk("lb3", dout, 32'h00000012);

    load(32'd0, SZ_X, 1'b0);
    chk("size11_exc", {31'd0, exception}, 32'd1);
    chk("size11_dout", dout, 32'h0);
    load(32'h00001000, SZ_W, 1'b0);
    chk("range_exc", {31'd0, exception}, 32'd1);
    chk("range_dout", dout, 32'h0);

    memRead = 1'b0; memWrite = 1'b0; addr = 32'd3; memSize = SZ_W;
    #1;
    chk("idle_exc", {31'd0, exception}, 32'd0);
    chk("idle_dout", dout, 32'h0);

    // Simultaneous load and store: old data before the edge, new data after.
    @(negedge clk);
    addr = 32'd0; din = 32'hCAFEBABE; memSize = SZ_W; memSign = 1'b0;
    memRead = 1'b1; memWrite = 1'b1;
    #1;
    chk("rw_pre", dout, 32'h12345678);
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    chk("rw_post", dout, 32'hCAFEBABE);

    @(negedge clk);
    #3;
    reset = 1'b1;
    load(32'd0, SZ_W, 1'b0);
    chk("rst_lw0", dout, 32'h0);
    reset = 1'b0;
    #1;
    load(32'd0, SZ_W, 1'b0);
    chk("post_rst_lw0", dout, 32'h0);
    load(32'd4, SZ_W, 1'b0);
    chk("post_rst_lw4", dout, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    addr = 32'd8; din = 32'hAABBCCDD; memSize = SZ_W; memWrite = 1'b1; memRead = 1'b0;
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    reset = 1'b0;
    load(32'd8, SZ_W, 1'b0);
    chk("rst_store_blocked", dout, 32'h0);

    store(32'd8, 32'hAABBCCDD, SZ_W);
    load(32'd8, SZ_W, 1'b0);
    chk("store_after_rst", dout, 32'hAABBCCDD);

    idle();
    #10;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish before 20000ns");
    $fatal(1);
  end

endmodule
